projectile_scheduler: RTL
=========================

PROJECTILE_SCHEDULER -- requirements
Module: projectile_scheduler

Interface
REQ-001 Parameter NUM_SLOTS, default 12, number of shared projectile slots.
REQ-002 Parameter STEP, default 2, pixels moved per move_tick.
REQ-003 Parameter COOLDOWN, default 8, move_ticks a player must wait after a grant before the next shot is accepted.
REQ-004 clk  in  1  system clock; the block has one clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 move_tick  in  1  one-cycle pulse that advances every projectile.
REQ-007 p1_shoot, p2_shoot  in  1 each  one-cycle shoot request pulses (player1 is Charmander, player2 is Squirtle).
REQ-008 p1_topY, p2_topY  in  6 each  current sprite top Y coordinates.
REQ-009 slot_en  out  NUM_SLOTS  slot active flags.
REQ-010 slot_owner  out  NUM_SLOTS  per slot: 0 = fireball from p1, 1 = waterball from p2.
REQ-011 slot_x  out  7*NUM_SLOTS  packed left X coordinates; slot i occupies bits [7i+6:7i].
REQ-012 slot_y  out  6*NUM_SLOTS  packed top Y coordinates; slot i occupies bits [6i+5:6i].
REQ-013 p1_grant, p2_grant  out  1 each  one-cycle pulse when a shot is allocated to a slot.
REQ-014 hit_p1, hit_p2  out  1 each  one-cycle pulse when that player's sprite is hit.

Function
REQ-015 Geometry is fixed:
- Screen is 96x64.
- Sprites are 22x22; p1 left X = 0, p2 left X = 74.
- Balls are 4x4.
REQ-016 Shoot pulse handling:
- A shoot pulse sets the player's pending flag only when that player's cooldown is 0 and no request is already pending.
- Any other shoot pulse is ignored.
REQ-017 Grant rules:
- At most one grant per cycle.
- The grant goes to the lowest-index free slot.
- With no free slot, pending requests are held.
REQ-018 When both players are pending, the player named by the priority pointer is granted; the pointer then moves to the other player; the pointer is unchanged on uncontested grants.
REQ-019 Spawn position on grant:
- p1: x = 22, y = p1_topY + 9.
- p2: x = 70, y = p2_topY + 9.
- slot_en is set and owner is recorded.
REQ-020 On a grant:
- the grant pulse and the slot contents are visible the cycle after the cycle in which the flag is pending;
- the player's pending flag clears;
- the player's cooldown loads COOLDOWN.
REQ-021 Movement on move_tick:
- Every active slot not spawned in that same cycle moves.
- Owner 0 moves x += STEP; owner 1 moves x -= STEP.
- Arithmetic is 8-bit, then compared.
REQ-022 Owner-0 slot end condition:
- Triggers when new x >= 70.
- If the ball's Y range overlaps p2's Y range, hit_p2 pulses; Y ranges overlap when y+3 >= topY and y <= topY+21.
- The slot frees in the same update regardless of hit or miss.
REQ-023 Owner-1 slot end condition:
- Triggers when new x <= 22 (underflow counts as <= 22).
- If the ball's Y range overlaps p1's Y range, hit_p1 pulses.
- The slot frees in the same update.
REQ-024 Multiple hits on one player in the same tick produce a single hit pulse.
REQ-025 Each cooldown counter decrements on move_tick while it is nonzero, saturating at 0.
REQ-026 A slot freed on a tick is not reusable until the following cycle.
REQ-027 Spawn Y above 63 saturates to 60.
REQ-028 Outputs are registered; no combinational path runs from the inputs to the outputs.

Reset
REQ-029 Reset clears the following, and reset mid-flight drops all projectiles and pending shots without pulses:
- slot_en, slot_owner, slot_x and slot_y become 0;
- pending flags and cooldowns become 0;
- the priority pointer becomes p1;
- all pulse outputs become 0.
REQ-030 Reset takes priority over all events in the same cycle.

Structure
REQ-031 Shared package pokemon_pkg holds:
- SCREEN_W = 96, SCREEN_H = 64;
- SPRITE_W = 22, BALL_W = 4;
- P1_LEFTX = 0, P2_LEFTX = 74;
- the owner encoding.
REQ-032 The per-player pending/cooldown logic is instantiated twice as sub-module shot_cooldown.
REQ-033 Slot state is an array of NUM_SLOTS records; the free-slot search is a priority encoder.

Verification
REQ-034 Reset, then p1_shoot with p1_topY = 20 -> next cycle: p1_grant = 1, slot 0 at x = 22, y = 29, owner 0.
REQ-035 Scenario continues from REQ-034 with p2_topY = 20; after 24 move_ticks -> x reaches 70, hit_p2 pulses once, slot_en[0] = 0.
REQ-036 Same as REQ-035 but p2_topY = 40 -> no hit_p2, slot 0 freed at x = 70.
REQ-037 p1_shoot and p2_shoot in the same cycle after reset -> p1 takes slot 0, then p2 takes slot 1 the next cycle; repeat after cooldown -> p2 is granted first.
REQ-038 All 12 slots active, then p2_shoot -> request held; the grant occurs the cycle after the first slot frees and uses that slot index.
REQ-039 p1_shoot 3 move_ticks after a grant -> ignored, no pending; a shoot after 8 ticks -> granted.

Source files
------------

// File: rtl/pokemon_pkg.sv
// Shared arena geometry, slot owner encoding and slot record for the projectile scheduler.
// Pure definitions: no state, no latency, no flow control.
package pokemon_pkg;

  localparam int SCREEN_W = 96;
  localparam int SCREEN_H = 64;
  localparam int SPRITE_W = 22;
  localparam int BALL_W   = 4;
  localparam int P1_LEFTX = 0;
  localparam int P2_LEFTX = 74;
  localparam int SPAWN_DY = 9;

  // Balls spawn flush against the shooter's sprite edge; reaching the opposite spawn X ends flight.
  localparam logic [6:0] P1_SPAWN_X = 7'(P1_LEFTX + SPRITE_W);
  localparam logic [6:0] P2_SPAWN_X = 7'(P2_LEFTX - BALL_W);
  localparam logic [5:0] Y_SAT      = 6'(SCREEN_H - BALL_W);

  typedef enum logic {
    OWNER_P1 = 1'b0,
    OWNER_P2 = 1'b1
  } owner_e;

  typedef struct packed {
    logic       en;
    owner_e     owner;
    logic [6:0] x;
    logic [5:0] y;
  } slot_t;

  function automatic logic [5:0] spawn_y(input logic [5:0] top_y);
    logic [6:0] s;
    s = {1'b0, top_y} + 7'(SPAWN_DY);
    return (s > 7'd63) ? Y_SAT : s[5:0];
  endfunction

  function automatic logic y_overlap(input logic [5:0] ball_y, input logic [5:0] top_y);
    logic [6:0] by;
    logic [6:0] ty;
    by = {1'b0, ball_y};
    ty = {1'b0, top_y};
    return ((by + 7'(BALL_W - 1)) >= ty) && (by <= (ty + 7'(SPRITE_W - 1)));
  endfunction

endpackage

// File: rtl/shot_cooldown.sv
// Per-player shot request latch plus move_tick cooldown; pending is registered, cleared by grant.
// Latency: shoot visible as pending one cycle later; shoots during cooldown or while pending are dropped.
module shot_cooldown #(
  parameter int COOLDOWN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic move_tick,
  input  logic shoot,
  input  logic grant,
  output logic pending
);

  localparam int CW = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);

  logic          pending_q, pending_d;
  logic [CW-1:0] cd_q, cd_d;

  always_comb begin
    pending_d = pending_q;
    cd_d      = cd_q;
    if (move_tick && (cd_q != '0)) begin
      cd_d = cd_q - CW'(1);
    end
    // A grant reloads the cooldown even on a tick cycle.
    if (grant) begin
      pending_d = 1'b0;
      cd_d      = CW'(COOLDOWN);
    end else if (shoot && !pending_q && (cd_q == '0)) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= 1'b0;
      cd_q      <= '0;
    end else begin
      pending_q <= pending_d;
      cd_q      <= cd_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/projectile_scheduler.sv
// Shared projectile slot pool: round-robin grant of pending shots, ball movement, hit detection.
// Latency: grant and slot contents appear one cycle after the request is pending; full pool holds requests.
module projectile_scheduler
  import pokemon_pkg::*;
#(
  parameter int NUM_SLOTS = 12,
  parameter int STEP      = 2,
  parameter int COOLDOWN  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   move_tick,
  input  logic                   p1_shoot,
  input  logic                   p2_shoot,
  input  logic [5:0]             p1_topY,
  input  logic [5:0]             p2_topY,
  output logic [NUM_SLOTS-1:0]   slot_en,
  output logic [NUM_SLOTS-1:0]   slot_owner,
  output logic [7*NUM_SLOTS-1:0] slot_x,
  output logic [6*NUM_SLOTS-1:0] slot_y,
  output logic                   p1_grant,
  output logic                   p2_grant,
  output logic                   hit_p1,
  output logic                   hit_p2
);

  localparam int IW = (NUM_SLOTS < 2) ? 1 : $clog2(NUM_SLOTS);

  slot_t   slot_q [NUM_SLOTS];
  slot_t   slot_d [NUM_SLOTS];
  logic    prio_q, prio_d;
  logic    p1_grant_q, p2_grant_q, hit_p1_q, hit_p2_q;
  logic    hit_p1_d, hit_p2_d;
  logic    p1_pend, p2_pend;
  logic    gnt1, gnt2;
  logic    free_vld;
  logic [IW-1:0] free_idx;

  shot_cooldown #(.COOLDOWN(COOLDOWN)) u_cd_p1 (
    .clk      (clk),
    .reset    (reset),
    .move_tick(move_tick),
    .shoot    (p1_shoot),
    .grant    (gnt1),
    .pending  (p1_pend)
  );

  shot_cooldown #(.COOLDOWN(COOLDOWN)) u_cd_p2 (
    .clk      (clk),
    .reset    (reset),
    .move_tick(move_tick),
    .shoot    (p2_shoot),
    .grant    (gnt2),
    .pending  (p2_pend)
  );

  // Lowest-index free slot; uses registered state so a slot freed this tick is not reused yet.
  always_comb begin
    free_vld = 1'b0;
    free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slot_q[i].en) begin
        free_vld = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  // prio_q == 0 favours p1; it only flips when both players contend.
  always_comb begin
    gnt1   = free_vld && p1_pend && (!p2_pend || !prio_q);
    gnt2   = free_vld && p2_pend && (!p1_pend || prio_q);
    prio_d = (free_vld && p1_pend && p2_pend) ? ~prio_q : prio_q;
  end

  always_comb begin
    logic [7:0] nx;
    hit_p1_d = 1'b0;
    hit_p2_d = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_d[i] = slot_q[i];
      nx        = {1'b0, slot_q[i].x};
      if (move_tick && slot_q[i].en) begin
        if (slot_q[i].owner == OWNER_P1) begin
          nx          = {1'b0, slot_q[i].x} + 8'(STEP);
          slot_d[i].x = nx[6:0];
          if (nx >= {1'b0, P2_SPAWN_X}) begin
            slot_d[i].en = 1'b0;
            if (y_overlap(slot_q[i].y, p2_topY)) hit_p2_d = 1'b1;
          end
        end else begin
          // Bit 7 set after subtraction means the ball wrapped below zero.
          nx          = {1'b0, slot_q[i].x} - 8'(STEP);
          slot_d[i].x = nx[6:0];
          if (nx[7] || (nx <= {1'b0, P1_SPAWN_X})) begin
            slot_d[i].en = 1'b0;
            if (y_overlap(slot_q[i].y, p1_topY)) hit_p1_d = 1'b1;
          end
        end
      end
      if ((gnt1 || gnt2) && (free_idx == IW'(i))) begin
        slot_d[i].en    = 1'b1;
        slot_d[i].owner = gnt2 ? OWNER_P2 : OWNER_P1;
        slot_d[i].x     = gnt2 ? P2_SPAWN_X : P1_SPAWN_X;
        slot_d[i].y     = spawn_y(gnt2 ? p2_topY : p1_topY);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= '0;
      prio_q     <= 1'b0;
      p1_grant_q <= 1'b0;
      p2_grant_q <= 1'b0;
      hit_p1_q   <= 1'b0;
      hit_p2_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= slot_d[i];
      prio_q     <= prio_d;
      p1_grant_q <= gnt1;
      p2_grant_q <= gnt2;
      hit_p1_q   <= hit_p1_d;
      hit_p2_q   <= hit_p2_d;
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_out
    assign slot_en[g]          = slot_q[g].en;
    assign slot_owner[g]       = slot_q[g].owner;
    assign slot_x[7*g +: 7]    = slot_q[g].x;
    assign slot_y[6*g +: 6]    = slot_q[g].y;
  end

  assign p1_grant = p1_grant_q;
  assign p2_grant = p2_grant_q;
  assign hit_p1   = hit_p1_q;
  assign hit_p2   = hit_p2_q;

endmodule
